control_sequencer: RTL and testbench

Multi-cycle control unit for the 8-bit core. It fetches instruction bytes from memory and decodes NOP, LDX, AOP and HLT. It then drives the register file, ALU, address registers and memory controller field by field, using the shared control package encodings (`alu_op_e`, `register_sel_e`, `addr_reg_op_e`, `addr_sel_e`, `mem_ctrl_op_e`, `register_in_source_e`). It sits directly upstream of the datapath and consumes the data bus and ALU flags.

---
 rtl/control_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | control_sequencer                                                          |
// | Multi-cycle fetch/decode/execute control unit for the 8-bit core (NOP,    |
// | LDX, AOP, HLT). Macro SEQ_ILLEGAL_TRAP_EN: illegal opcodes halt and set a  |
// | sticky illegal_o; otherwise they act as NOP with a one-cycle illegal_o.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module control_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bus_i,
  input  logic       mem_ready_i,
  input  logic [1:0] alu_flags_i,
  input  logic       resume_i,
  output logic [3:0] alu_op_o,
  output logic [1:0] sel_in_o,
  output logic [1:0] sel_reg1_o,
  output logic [1:0] sel_reg2_o,
  output logic       in_source_o,
  output logic       reg_op_o,
  output logic [1:0] mem_op_o,
  output logic       addr_sel_o,
  output logic [2:0] addr_reg_op_o,
  output logic [7:0] addr_load_o,
  output logic [1:0] flags_o,
  output logic       halted_o,
  output logic       illegal_o
);

  localparam logic [3:0] OPC_NOP     = 4'h0;
  localparam logic [3:0] OPC_LDX     = 4'h1;
  localparam logic [3:0] OPC_AOP     = 4'h2;
  localparam logic [3:0] OPC_HLT     = 4'hF;
  localparam logic [3:0] ALUNOP      = 4'h0;
  localparam logic [1:0] REG_A       = 2'd0;
  localparam logic       IN_ALU      = 1'b0;
  localparam logic       IN_BUS      = 1'b1;
  localparam logic [1:0] MEM_NOP     = 2'd0;
  localparam logic [1:0] MEM_READ    = 2'd1;
  localparam logic       ADDR_PC     = 1'b0;
  localparam logic       ADDR_MAR    = 1'b1;
  localparam logic [2:0] AR_NOP      = 3'd0;
  localparam logic [2:0] AR_INC      = 3'd1;
  localparam logic [2:0] AR_ABSOLUTE = 3'd2;

`ifdef SEQ_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_INC1, S_OPERAND, S_MARLD, S_INC2, S_EXEC, S_HALT
  } state_t;

  state_t     state, state_nx;
  logic [7:0] ir, ir_nx, opr_nx;
  logic [1:0] flags_nx;
  logic       illegal_nx;
  logic       exec_ldx, aop_write;

  logic [3:0] d_alu;
  logic [1:0] d_sel_in, d_sel_reg1, d_sel_reg2, d_mem_op;
  logic       d_in_source, d_aop_write, d_exec_ldx, d_addr_sel;
  logic [2:0] d_addr_reg_op;

  function automatic logic is_illegal(input logic [7:0] b);
    return !(b[7:4] inside {OPC_NOP, OPC_LDX, OPC_AOP, OPC_HLT});
  endfunction

  // Next architectural state; addr_load_o doubles as the operand register.
  always_comb begin
    state_nx = state;
    ir_nx    = ir;
    opr_nx   = addr_load_o;
    flags_nx = flags_o;
    case (state)
      S_IDLE:  state_nx = S_FETCH;
      S_FETCH: if (mem_ready_i) begin
        ir_nx    = bus_i;
        state_nx = S_INC1;
      end
      S_INC1: begin
        if (ir[7:4] == OPC_NOP)                           state_nx = S_FETCH;
        else if (ir[7:4] == OPC_HLT)                      state_nx = S_HALT;
        else if (ir[7:4] == OPC_LDX || ir[7:4] == OPC_AOP) state_nx = S_OPERAND;
        else                                              state_nx = TRAP ? S_HALT : S_FETCH;
      end
      S_OPERAND: if (mem_ready_i) begin
        opr_nx   = bus_i;
        state_nx = (ir[7:4] == OPC_LDX) ? S_MARLD : S_INC2;
      end
      S_MARLD: state_nx = S_INC2;
      S_INC2:  state_nx = S_EXEC;
      S_EXEC: begin
        if (ir[7:4] == OPC_LDX) begin
          if (mem_ready_i) state_nx = S_FETCH;
        end else begin
          flags_nx = alu_flags_i;
          state_nx = S_FETCH;
        end
      end
      S_HALT:  if (resume_i) state_nx = S_FETCH;
      default: state_nx = S_IDLE;
    endcase
    illegal_nx = (TRAP & illegal_o) | ((state_nx == S_INC1) & is_illegal(ir_nx));
  end

  // Outputs for the state being entered, so they can be registered.
  always_comb begin
    d_alu         = ALUNOP;
    d_sel_in      = REG_A;
    d_sel_reg1    = REG_A;
    d_sel_reg2    = REG_A;
    d_in_source   = IN_ALU;
    d_aop_write   = 1'b0;
    d_exec_ldx    = 1'b0;
    d_mem_op      = MEM_NOP;
    d_addr_sel    = ADDR_PC;
    d_addr_reg_op = AR_NOP;
    case (state_nx)
      S_FETCH, S_OPERAND: d_mem_op = MEM_READ;
      S_INC1, S_INC2:     d_addr_reg_op = AR_INC;
      S_MARLD: begin
        d_addr_sel    = ADDR_MAR;
        d_addr_reg_op = AR_ABSOLUTE;
      end
      S_EXEC: begin
        if (ir_nx[7:4] == OPC_LDX) begin
          d_mem_op    = MEM_READ;
          d_addr_sel  = ADDR_MAR;
          d_in_source = IN_BUS;
          d_sel_in    = ir_nx[1:0];
          d_exec_ldx  = 1'b1;
        end else begin
          d_alu       = ir_nx[3:0];
          d_sel_reg1  = opr_nx[5:4];
          d_sel_reg2  = opr_nx[3:2];
          d_sel_in    = opr_nx[7:6];
          d_aop_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      ir            <= '0;
      addr_load_o   <= '0;
      flags_o       <= '0;
      halted_o      <= 1'b0;
      illegal_o     <= 1'b0;
      alu_op_o      <= ALUNOP;
      sel_in_o      <= REG_A;
      sel_reg1_o    <= REG_A;
      sel_reg2_o    <= REG_A;
      in_source_o   <= IN_ALU;
      aop_write     <= 1'b0;
      exec_ldx      <= 1'b0;
      mem_op_o      <= MEM_NOP;
      addr_sel_o    <= ADDR_PC;
      addr_reg_op_o <= AR_NOP;
    end else begin
      state         <= state_nx;
      ir            <= ir_nx;
      addr_load_o   <= opr_nx;
      flags_o       <= flags_nx;
      halted_o      <= (state_nx == S_HALT);
      illegal_o     <= illegal_nx;
      alu_op_o      <= d_alu;
      sel_in_o      <= d_sel_in;
      sel_reg1_o    <= d_sel_reg1;
      sel_reg2_o    <= d_sel_reg2;
      in_source_o   <= d_in_source;
      aop_write     <= d_aop_write;
      exec_ldx      <= d_exec_ldx;
      mem_op_o      <= d_mem_op;
      addr_sel_o    <= d_addr_sel;
      addr_reg_op_o <= d_addr_reg_op;
    end
  end

  // Load data is valid on the bus only in the ready cycle, so the LDX write is qualified by it.
  assign reg_op_o = aop_write | (exec_ldx & mem_ready_i);

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_control_sequencer                                                       |
// | Directed bench: an instruction-level model expands each instruction into   |
// | per-cycle input/expected-output records that are replayed against the DUT. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] bus_i = 8'h00;
  logic       mem_ready_i = 1'b0;
  logic [1:0] alu_flags_i = 2'b00;
  logic       resume_i = 1'b0;
  logic [3:0] alu_op_o;
  logic [1:0] sel_in_o, sel_reg1_o, sel_reg2_o, mem_op_o, flags_o;
  logic       in_source_o, reg_op_o, addr_sel_o, halted_o, illegal_o;
  logic [2:0] addr_reg_op_o;
  logic [7:0] addr_load_o;

  control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .bus_i(bus_i), .mem_ready_i(mem_ready_i),
    .alu_flags_i(alu_flags_i), .resume_i(resume_i), .alu_op_o(alu_op_o),
    .sel_in_o(sel_in_o), .sel_reg1_o(sel_reg1_o), .sel_reg2_o(sel_reg2_o),
    .in_source_o(in_source_o), .reg_op_o(reg_op_o), .mem_op_o(mem_op_o),
    .addr_sel_o(addr_sel_o), .addr_reg_op_o(addr_reg_op_o),
    .addr_load_o(addr_load_o), .flags_o(flags_o), .halted_o(halted_o),
    .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

`ifdef SEQ_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  // One clock cycle: inputs to drive, then the outputs expected in that cycle.
  typedef struct packed {
    logic [7:0] bus; logic rdy; logic [1:0] fl; logic res;
    logic [3:0] alu; logic [1:0] sin; logic [1:0] s1; logic [1:0] s2;
    logic src; logic rop; logic [1:0] mop; logic asel; logic [2:0] aop;
    logic [7:0] ald; logic [1:0] flg; logic hlt; logic ill;
  } cyc_t;

  cyc_t       exp_q[$];
  logic [7:0] m_or;
  logic [1:0] m_flags;
  logic       m_ill;
  int checks = 0, errors = 0, cyc = 0, n_wr = 0, n_inc = 0;

  function automatic cyc_t base();
    cyc_t c;
    c = '0;
    c.bus = 8'h5A; c.rdy = 1'b1; c.fl = 2'b10;
    c.ald = m_or; c.flg = m_flags; c.ill = m_ill;
    return c;
  endfunction

  function automatic logic illegal_op(input logic [7:0] b);
    return !(b[7:4] == 4'h0 || b[7:4] == 4'h1 || b[7:4] == 4'h2 || b[7:4] == 4'hF);
  endfunction

  task automatic model_reset(); m_or = '0; m_flags = '0; m_ill = 1'b0; endtask
  task automatic push_idle(); exp_q.push_back(base()); endtask

  task automatic mem_read(input logic [7:0] data, input int waits, input logic asel);
    cyc_t c;
    for (int i = 0; i < waits; i++) begin
      c = base(); c.rdy = 1'b0; c.bus = 8'hEE; c.mop = 2'd1; c.asel = asel;
      exp_q.push_back(c);
    end
    c = base(); c.bus = data; c.mop = 2'd1; c.asel = asel;
    exp_q.push_back(c);
  endtask

  task automatic pc_inc(input logic pulse);
    cyc_t c;
    c = base(); c.aop = 3'd1; c.ill = m_ill | pulse;
    exp_q.push_back(c);
  endtask

  task automatic fetch_dec(input logic [7:0] op, input int wf);
    mem_read(op, wf, 1'b0);
    if (TRAP && illegal_op(op)) m_ill = 1'b1;
    pc_inc(illegal_op(op));
  endtask

  task automatic halt_cycles(input int hold);
    cyc_t c;
    for (int i = 0; i <= hold; i++) begin
      c = base(); c.hlt = 1'b1; c.res = (i == hold);
      exp_q.push_back(c);
    end
  endtask

  task automatic do_aop(input logic [7:0] op, input logic [7:0] opnd, input logic [1:0] fin,
                        input int wf, input int wo);
    cyc_t c;
    fetch_dec(op, wf);
    mem_read(opnd, wo, 1'b0);
    m_or = opnd;
    pc_inc(1'b0);
    c = base(); c.rdy = 1'b0; c.fl = fin; c.alu = op[3:0];
    c.sin = opnd[7:6]; c.s1 = opnd[5:4]; c.s2 = opnd[3:2]; c.rop = 1'b1;
    exp_q.push_back(c);
    m_flags = fin;
  endtask

  task automatic do_ldx(input logic [7:0] op, input logic [7:0] addr,
                        input int wf, input int wo, input int we);
    cyc_t c;
    fetch_dec(op, wf);
    mem_read(addr, wo, 1'b0);
    m_or = addr;
    c = base(); c.asel = 1'b1; c.aop = 3'd2;
    exp_q.push_back(c);
    pc_inc(1'b0);
    for (int i = 0; i <= we; i++) begin
      c = base(); c.mop = 2'd1; c.asel = 1'b1; c.src = 1'b1; c.sin = op[1:0];
      c.rdy = (i == we); c.bus = 8'hC3; c.rop = (i == we);
      exp_q.push_back(c);
    end
  endtask

  function automatic logic [29:0] outs();
    return {alu_op_o, sel_in_o, sel_reg1_o, sel_reg2_o, in_source_o, reg_op_o,
            mem_op_o, addr_sel_o, addr_reg_op_o, addr_load_o, flags_o, halted_o, illegal_o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Replays up to n queued cycles (n < 0: all); entered just after a falling edge.
  task automatic replay(input int n);
    cyc_t c;
    n_wr = 0; n_inc = 0;
    while (exp_q.size() > 0 && n != 0) begin
      c = exp_q.pop_front();
      n--;
      bus_i = c.bus; mem_ready_i = c.rdy; alu_flags_i = c.fl; resume_i = c.res;
      #1;
      checks++;
      if (outs() !== c[29:0]) begin
        errors++;
        $display("FAIL cycle %0d outputs: got %h required %h", cyc, outs(), c[29:0]);
      end
      if (reg_op_o === 1'b1) n_wr++;
      if (addr_reg_op_o === 3'd1 && addr_sel_o === 1'b0) n_inc++;
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cyc_t c;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset outputs", {2'b0, outs()}, 32'h0);
    rst_n = 1'b1;

    // NOP: IDLE, FETCH, INC1 then the next fetch; one PC increment, no write.
    push_idle();
    fetch_dec(8'h00, 0);
    replay(-1);
    check("nop pc inc count", n_inc, 1);
    check("nop reg writes", n_wr, 0);

    // AOP ADD dest B, reg1 C, reg2 B with flags 11.
    do_aop(8'h22, 8'h64, 2'b11, 0, 0);
    check("aop model length", exp_q.size(), 5);
    c = exp_q[4];
    check("aop model exec fields", {c.alu, c.sin, c.s1, c.s2, c.rop}, {4'h2, 2'd1, 2'd2, 2'd1, 1'b1});
    replay(-1);
    check("aop reg writes", n_wr, 1);
    check("aop flags latched", flags_o, 2'b11);

    // AOP with ALU nibble above 11, memory waits on fetch and operand.
    do_aop(8'h2D, 8'hE4, 2'b01, 2, 1);
    replay(-1);
    check("aop2 flags latched", flags_o, 2'b01);

    // LDX to D from 0x80 with three EXEC wait cycles: 9 cycles.
    do_ldx(8'h13, 8'h80, 0, 0, 3);
    check("ldx model length", exp_q.size(), 9);
    replay(-1);
    check("ldx reg writes", n_wr, 1);
    check("ldx operand held", addr_load_o, 8'h80);

    do_ldx(8'h11, 8'h3C, 1, 2, 0);
    replay(-1);

    // HLT held for 10 cycles, resume, then a NOP fetch follows immediately.
    fetch_dec(8'hF0, 0);
    halt_cycles(10);
    fetch_dec(8'h00, 0);
    replay(-1);
    check("hlt reg writes", n_wr, 0);

    // Illegal opcode 0x70.
    fetch_dec(8'h70, 0);
    if (TRAP) halt_cycles(3);
    fetch_dec(8'h00, 0);
    replay(-1);
    check("illegal after recovery", illegal_o, TRAP);

    // Reset dropped during the EXEC wait of an LDX, with ready high at that moment.
    do_ldx(8'h12, 8'h40, 0, 0, 5);
    replay(8);
    exp_q.delete();
    rst_n = 1'b0; mem_ready_i = 1'b1; bus_i = 8'h99;
    #1;
    check("async reset outputs", {2'b0, outs()}, 32'h0);
    check("async reset no write", reg_op_o, 1'b0);
    @(negedge clk);
    #1;
    check("reset held outputs", {2'b0, outs()}, 32'h0);
    rst_n = 1'b1;
    model_reset();
    push_idle();
    do_aop(8'h21, 8'h1C, 2'b10, 0, 0);
    replay(-1);
    check("post reset flags", flags_o, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
